// File: rtl/fir_xifu_ctrl.sv
// In-order scoreboard and issue scheduler for offloaded XIFU instructions.
// Optional perf counters: define FIR_XIFU_CTRL_PERF_EN.
module fir_xifu_ctrl #(
  parameter int NB_REGS     = 4,
  parameter int NB_INFLIGHT = 4,
  parameter int ID_WIDTH    = 4,
  localparam int RW = $clog2(NB_REGS),
  localparam int IW = $clog2(NB_INFLIGHT),
  localparam int CW = IW + 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                issue_valid_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [RW-1:0]       issue_rd_i,
  input  logic                issue_rd_we_i,
  input  logic [RW-1:0]       issue_rs1_i,
  input  logic [RW-1:0]       issue_rs2_i,
  input  logic [1:0]          issue_rs_use_i,
  output logic                issue_ready_o,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  input  logic                retire_valid_i,
  input  logic [ID_WIDTH-1:0] retire_id_i,
  output logic [NB_REGS-1:0]  regs_busy_o,
  output logic [CW-1:0]       inflight_cnt_o,
  output logic                kill_o,
  output logic [ID_WIDTH-1:0] kill_id_o,
`ifdef FIR_XIFU_CTRL_PERF_EN
  output logic [31:0]         perf_stall_o,
  output logic [31:0]         perf_retired_o,
`endif
  output logic                err_o
);

  logic [NB_INFLIGHT-1:0]               valid_q, valid_d, cmt_q, cmt_d, we_q, we_d;
  logic [NB_INFLIGHT-1:0][ID_WIDTH-1:0] id_q, id_d;
  logic [NB_INFLIGHT-1:0][RW-1:0]       rd_q, rd_d;
  logic [IW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NB_REGS-1:0]  busy_q, busy_d;
  logic                kill_q, kill_d, err_q, err_d;
  logic [ID_WIDTH-1:0] kill_id_q, kill_id_d;

  logic          hazard_s, full_s, kill_req_s, accept_s, ret_ok_s, cm_hit_s;
  logic [IW-1:0] cm_idx_s, kill_age_s;

  // Issue gating and commit lookup, all from registered state.
  always_comb begin
    hazard_s = 1'b0;
    cm_hit_s = 1'b0;
    cm_idx_s = '0;
    for (int i = 0; i < NB_INFLIGHT; i++) begin
      hazard_s = hazard_s | (valid_q[i] & we_q[i] &
                 ((issue_rs_use_i[0] & (rd_q[i] == issue_rs1_i)) |
                  (issue_rs_use_i[1] & (rd_q[i] == issue_rs2_i)) |
                  (issue_rd_we_i & (rd_q[i] == issue_rd_i))));
      if (!cm_hit_s && valid_q[i] && !cmt_q[i] && (id_q[i] == commit_id_i)) begin
        cm_hit_s = 1'b1;
        cm_idx_s = IW'(i);
      end else begin
        cm_hit_s = cm_hit_s;
      end
    end
    full_s        = (cnt_q == CW'(NB_INFLIGHT));
    kill_req_s    = commit_valid_i & commit_kill_i;
    issue_ready_o = ~full_s & ~kill_req_s & ~hazard_s;
    accept_s      = issue_valid_i & issue_ready_o;
    ret_ok_s      = retire_valid_i & valid_q[head_q] & cmt_q[head_q] &
                    (id_q[head_q] == retire_id_i);
    kill_age_s    = cm_idx_s - head_q;
  end

  // Next-state: retire, then commit/kill, then accept.
  always_comb begin
    valid_d   = valid_q;
    cmt_d     = cmt_q;
    we_d      = we_q;
    id_d      = id_q;
    rd_d      = rd_q;
    head_d    = head_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    kill_d    = 1'b0;
    kill_id_d = kill_id_q;
    if (clear_i) begin
      valid_d   = '0;
      cmt_d     = '0;
      we_d      = '0;
      id_d      = '0;
      rd_d      = '0;
      head_d    = '0;
      tail_d    = '0;
      cnt_d     = '0;
      kill_id_d = '0;
    end else begin
      if (ret_ok_s) begin
        valid_d[head_q] = 1'b0;
        cmt_d[head_q]   = 1'b0;
        head_d          = head_q + IW'(1);
      end else if (retire_valid_i) begin
        err_d = 1'b1;
      end else begin
        err_d = err_d;
      end
      if (kill_req_s && cm_hit_s) begin
        // Everything at or beyond the killed entry's age is younger and dropped.
        for (int i = 0; i < NB_INFLIGHT; i++) begin
          if (valid_q[i] && (IW'(IW'(i) - head_q) >= kill_age_s)) begin
            valid_d[i] = 1'b0;
            cmt_d[i]   = 1'b0;
          end else begin
            valid_d[i] = valid_d[i];
          end
        end
        tail_d = cm_idx_s;
        cnt_d  = CW'(kill_age_s) - CW'(ret_ok_s);
      end else begin
        if (commit_valid_i && cm_hit_s) begin
          cmt_d[cm_idx_s] = 1'b1;
        end else begin
          cmt_d = cmt_d;
        end
        if (accept_s) begin
          valid_d[tail_q] = 1'b1;
          cmt_d[tail_q]   = 1'b0;
          we_d[tail_q]    = issue_rd_we_i;
          id_d[tail_q]    = issue_id_i;
          rd_d[tail_q]    = issue_rd_i;
          tail_d          = tail_q + IW'(1);
        end else begin
          tail_d = tail_q;
        end
        cnt_d = cnt_q - CW'(ret_ok_s) + CW'(accept_s);
      end
      if (commit_valid_i && !cm_hit_s) begin
        err_d = 1'b1;
      end else begin
        err_d = err_d;
      end
      if (kill_req_s) begin
        kill_d    = 1'b1;
        kill_id_d = commit_id_i;
      end else begin
        kill_d = 1'b0;
      end
    end
  end

  // Busy map of the next state, so the registered output tracks the table.
  always_comb begin
    busy_d = '0;
    for (int i = 0; i < NB_INFLIGHT; i++) begin
      if (valid_d[i] && we_d[i]) begin
        busy_d[rd_d[i]] = 1'b1;
      end else begin
        busy_d = busy_d;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q   <= '0;
      cmt_q     <= '0;
      we_q      <= '0;
      id_q      <= '0;
      rd_q      <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= '0;
      kill_q    <= 1'b0;
      kill_id_q <= '0;
      err_q     <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      cmt_q     <= cmt_d;
      we_q      <= we_d;
      id_q      <= id_d;
      rd_q      <= rd_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      kill_q    <= kill_d;
      kill_id_q <= kill_id_d;
      err_q     <= err_d;
    end
  end

  assign regs_busy_o    = busy_q;
  assign inflight_cnt_o = cnt_q;
  assign kill_o         = kill_q;
  assign kill_id_o      = kill_id_q;
  assign err_o          = err_q;

`ifdef FIR_XIFU_CTRL_PERF_EN
  logic [31:0] stall_q, stall_d, retired_q, retired_d;

  // Saturating performance counters.
  always_comb begin
    stall_d   = stall_q;
    retired_d = retired_q;
    if (clear_i) begin
      stall_d   = 32'd0;
      retired_d = 32'd0;
    end else begin
      if (issue_valid_i && !issue_ready_o && (stall_q != 32'hFFFF_FFFF)) begin
        stall_d = stall_q + 32'd1;
      end else begin
        stall_d = stall_q;
      end
      if (ret_ok_s && (retired_q != 32'hFFFF_FFFF)) begin
        retired_d = retired_q + 32'd1;
      end else begin
        retired_d = retired_q;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_q   <= 32'd0;
      retired_q <= 32'd0;
    end else begin
      stall_q   <= stall_d;
      retired_q <= retired_d;
    end
  end

  assign perf_stall_o   = stall_q;
  assign perf_retired_o = retired_q;
`endif

endmodule

// File: tb/tb_fir_xifu_ctrl.sv
// Self-checking bench for fir_xifu_ctrl: vector table plus hand-written corner sequences.
module tb_fir_xifu_ctrl;

  logic       clk = 1'b0;
  logic       rst_ni, clear_i;
  logic       issue_valid_i, issue_rd_we_i, issue_ready_o;
  logic [3:0] issue_id_i;
  logic [1:0] issue_rd_i, issue_rs1_i, issue_rs2_i, issue_rs_use_i;
  logic       commit_valid_i, commit_kill_i, retire_valid_i;
  logic [3:0] commit_id_i, retire_id_i;
  logic [3:0] regs_busy_o;
  logic [2:0] inflight_cnt_o;
  logic       kill_o, err_o;
  logic [3:0] kill_id_o;
`ifdef FIR_XIFU_CTRL_PERF_EN
  logic [31:0] perf_stall_o, perf_retired_o;
`endif

  int checks = 0;
  int errors = 0;
  int kill_exp[$];

  always #5 clk = ~clk;

  fir_xifu_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
    .issue_valid_i(issue_valid_i), .issue_id_i(issue_id_i), .issue_rd_i(issue_rd_i),
    .issue_rd_we_i(issue_rd_we_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_rs_use_i(issue_rs_use_i), .issue_ready_o(issue_ready_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .retire_valid_i(retire_valid_i), .retire_id_i(retire_id_i),
    .regs_busy_o(regs_busy_o), .inflight_cnt_o(inflight_cnt_o),
    .kill_o(kill_o), .kill_id_o(kill_id_o),
`ifdef FIR_XIFU_CTRL_PERF_EN
    .perf_stall_o(perf_stall_o), .perf_retired_o(perf_retired_o),
`endif
    .err_o(err_o)
  );

  typedef struct {
    logic       iv;
    logic [3:0] iid;
    logic [1:0] rd;
    logic       we;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [1:0] us;
    logic       cv;
    logic [3:0] cid;
    logic       ret;
    logic [3:0] rid;
    logic       clr;
    logic       rdy;
    logic [2:0] cnt;
    logic [3:0] busy;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(int iv, int iid, int rd, int we, int rs1, int us,
                              int cv, int cid, int ret, int rid, int clr,
                              int rdy, int cnt, int busy);
    vec_t v;
    v.iv = 1'(iv);   v.iid = 4'(iid); v.rd = 2'(rd);   v.we = 1'(we);
    v.rs1 = 2'(rs1); v.rs2 = 2'd0;    v.us = 2'(us);
    v.cv = 1'(cv);   v.cid = 4'(cid); v.ret = 1'(ret); v.rid = 4'(rid);
    v.clr = 1'(clr); v.rdy = 1'(rdy); v.cnt = 3'(cnt); v.busy = 4'(busy);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    clear_i = 1'b0; issue_valid_i = 1'b0; issue_id_i = 4'd0; issue_rd_i = 2'd0;
    issue_rd_we_i = 1'b0; issue_rs1_i = 2'd0; issue_rs2_i = 2'd0; issue_rs_use_i = 2'd0;
    commit_valid_i = 1'b0; commit_id_i = 4'd0; commit_kill_i = 1'b0;
    retire_valid_i = 1'b0; retire_id_i = 4'd0;
  endtask

  task automatic set_iss(input int id, input int rd, input int we, input int rs1, input int us);
    issue_valid_i = 1'b1; issue_id_i = 4'(id); issue_rd_i = 2'(rd); issue_rd_we_i = 1'(we);
    issue_rs1_i = 2'(rs1); issue_rs2_i = 2'd0; issue_rs_use_i = 2'(us);
  endtask

  // Advance one clock; the kill scoreboard is compared right after every edge.
  task automatic tick();
    int e;
    @(posedge clk);
    #1;
    if (kill_exp.size() > 0) begin
      e = kill_exp.pop_front();
      chk("kill_pulse", 32'(kill_o), 32'd1);
      chk("kill_id", 32'(kill_id_o), 32'(e));
    end else begin
      chk("kill_idle", 32'(kill_o), 32'd0);
    end
  endtask

  initial begin
    idle();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    chk("rst_cnt", 32'(inflight_cnt_o), 32'd0);
    chk("rst_busy", 32'(regs_busy_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_kill_id", 32'(kill_id_o), 32'd0);
    set_iss(1, 0, 1, 0, 0);
    #1 chk("rst_ready", 32'(issue_ready_o), 32'd1);

    //           iv iid rd we rs1 us cv cid ret rid clr rdy cnt busy
    tbl[0]  = mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b0001);
    tbl[1]  = mk(1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 4'b0011);
    tbl[2]  = mk(1, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 4'b0111);
    tbl[3]  = mk(1, 4, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4, 4'b1111);
    tbl[4]  = mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 4'b1111);
    tbl[5]  = mk(1, 5, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 4, 4'b1111);
    tbl[6]  = mk(1, 5, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3, 4'b1110);
    tbl[7]  = mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4, 4'b1111);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000);
    tbl[9]  = mk(1, 5, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b0100);
    tbl[10] = mk(1, 6, 3, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 4'b0100);
    tbl[11] = mk(1, 6, 3, 1, 2, 1, 1, 5, 0, 0, 0, 0, 1, 4'b0100);
    tbl[12] = mk(1, 6, 3, 1, 2, 1, 0, 0, 1, 5, 0, 0, 0, 4'b0000);
    tbl[13] = mk(1, 6, 3, 1, 2, 1, 0, 0, 0, 0, 0, 1, 1, 4'b1000);

    for (int i = 0; i < 14; i++) begin
      idle();
      clear_i = tbl[i].clr;
      issue_valid_i = tbl[i].iv; issue_id_i = tbl[i].iid; issue_rd_i = tbl[i].rd;
      issue_rd_we_i = tbl[i].we; issue_rs1_i = tbl[i].rs1; issue_rs2_i = tbl[i].rs2;
      issue_rs_use_i = tbl[i].us;
      commit_valid_i = tbl[i].cv; commit_id_i = tbl[i].cid;
      retire_valid_i = tbl[i].ret; retire_id_i = tbl[i].rid;
      #1 chk($sformatf("v%0d_ready", i), 32'(issue_ready_o), 32'(tbl[i].rdy));
      tick();
      chk($sformatf("v%0d_cnt", i), 32'(inflight_cnt_o), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_busy", i), 32'(regs_busy_o), 32'(tbl[i].busy));
      chk($sformatf("v%0d_err", i), 32'(err_o), 32'd0);
    end

    // Kill of id 2 drops ids 2 and 3 and blocks a same-cycle issue.
    idle(); clear_i = 1'b1; tick(); clear_i = 1'b0;
    for (int id = 1; id <= 3; id++) begin
      set_iss(id, id - 1, 1, 0, 0);
      tick();
    end
    chk("k_cnt3", 32'(inflight_cnt_o), 32'd3);
    set_iss(4, 3, 1, 0, 0);
    commit_valid_i = 1'b1; commit_id_i = 4'd2; commit_kill_i = 1'b1;
    kill_exp.push_back(2);
    #1 chk("k_ready", 32'(issue_ready_o), 32'd0);
    tick();
    chk("k_cnt1", 32'(inflight_cnt_o), 32'd1);
    chk("k_busy", 32'(regs_busy_o), 32'd1);
    idle();
    tick();
    chk("k_noacc", 32'(inflight_cnt_o), 32'd1);

    // Full table: retire frees a slot but the held issue lands one cycle later.
    for (int id = 5; id <= 7; id++) begin
      set_iss(id, id - 4, 1, 0, 0);
      #1 chk("f_ready", 32'(issue_ready_o), 32'd1);
      tick();
    end
    chk("f_cnt4", 32'(inflight_cnt_o), 32'd4);
    idle(); commit_valid_i = 1'b1; commit_id_i = 4'd1; tick(); idle();
    set_iss(8, 0, 0, 0, 0);
    retire_valid_i = 1'b1; retire_id_i = 4'd1;
    #1 chk("f_ready_ret", 32'(issue_ready_o), 32'd0);
    tick();
    chk("f_cnt3", 32'(inflight_cnt_o), 32'd3);
    retire_valid_i = 1'b0;
    #1 chk("f_ready_next", 32'(issue_ready_o), 32'd1);
    tick();
    chk("f_cnt4b", 32'(inflight_cnt_o), 32'd4);

    // Protocol errors are sticky across clear, cleared only by reset.
    idle(); retire_valid_i = 1'b1; retire_id_i = 4'd7; tick(); idle();
    chk("e_err", 32'(err_o), 32'd1);
    chk("e_cnt", 32'(inflight_cnt_o), 32'd4);
    chk("e_busy", 32'(regs_busy_o), 32'b1110);
    tick();
    chk("e_sticky", 32'(err_o), 32'd1);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    chk("e_clr_err", 32'(err_o), 32'd1);
    chk("e_clr_cnt", 32'(inflight_cnt_o), 32'd0);
    rst_ni = 1'b0; tick(); rst_ni = 1'b1;
    chk("e_rst_err", 32'(err_o), 32'd0);
    retire_valid_i = 1'b1; retire_id_i = 4'd0; tick(); idle();
    chk("e_empty_err", 32'(err_o), 32'd1);
    chk("e_empty_cnt", 32'(inflight_cnt_o), 32'd0);

`ifdef FIR_XIFU_CTRL_PERF_EN
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    set_iss(1, 0, 1, 0, 0); tick();
    set_iss(2, 1, 1, 0, 0); tick();
    set_iss(3, 2, 1, 0, 1);
    repeat (3) tick();
    idle();
    commit_valid_i = 1'b1; commit_id_i = 4'd1; tick();
    commit_id_i = 4'd2; tick();
    idle(); retire_valid_i = 1'b1; retire_id_i = 4'd1; tick();
    retire_id_i = 4'd2; tick();
    idle();
    chk("p_stall", perf_stall_o, 32'd3);
    chk("p_retired", perf_retired_o, 32'd2);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    chk("p_stall_clr", perf_stall_o, 32'd0);
    chk("p_retired_clr", perf_retired_o, 32'd0);
`endif

    rst_ni = 1'b0; tick(); rst_ni = 1'b1;
    chk("final_err", 32'(err_o), 32'd0);
    chk("final_cnt", 32'(inflight_cnt_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
